// File: rtl/ucsbece154b_branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB.
// Fetch lookup is combinational; Execute feeds resolved outcomes back.
module ucsbece154b_branch_predictor #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             PCF_i,
    output logic                    BranchTakenF_o,
    output logic [31:0]             BTBtargetF_o,
    output logic [NUM_GHR_BITS-1:0] PHTindexF_o,
    input  logic                    BranchE_i,
    input  logic                    JumpE_i,
    input  logic                    BranchTakenE_i,
    input  logic [31:0]             PCE_i,
    input  logic [31:0]             TargetE_i,
    input  logic [NUM_GHR_BITS-1:0] PHTindexE_i
);

    localparam int IDX  = $clog2(NUM_BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;
    localparam int PHTN = 1 << NUM_GHR_BITS;

    logic [NUM_BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_BTB_ENTRIES-1:0] is_jump_q, is_jump_d;
    logic [NUM_BTB_ENTRIES-1:0] is_branch_q, is_branch_d;
    logic [TAGW-1:0]            tag_q    [NUM_BTB_ENTRIES];
    logic [TAGW-1:0]            tag_d    [NUM_BTB_ENTRIES];
    logic [31:0]                target_q [NUM_BTB_ENTRIES];
    logic [31:0]                target_d [NUM_BTB_ENTRIES];
    logic [1:0]                 pht_q    [PHTN];
    logic [1:0]                 pht_d    [PHTN];
    logic [NUM_GHR_BITS-1:0]    ghr_q, ghr_d;

    logic [IDX-1:0]          f_idx, e_idx;
    logic [TAGW-1:0]         f_tag, e_tag;
    logic [NUM_GHR_BITS-1:0] f_pht_idx;
    logic [1:0]              f_ctr, e_ctr;
    logic                    f_hit, f_taken;
    logic                    unused_pc_bits;

    assign unused_pc_bits = ^{PCF_i[1:0], PCE_i[1:0]};

    assign f_idx = PCF_i[IDX+1:2];
    assign f_tag = PCF_i[31:IDX+2];
    assign e_idx = PCE_i[IDX+1:2];
    assign e_tag = PCE_i[31:IDX+2];

    // Lookup reads only the _q state, so same-cycle updates stay invisible.
    always_comb begin
        f_pht_idx      = PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
        f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        f_ctr          = pht_q[f_pht_idx];
        f_taken        = f_hit && (is_jump_q[f_idx]
                         || (is_branch_q[f_idx] && f_ctr[1]));
        BranchTakenF_o = reset && f_taken;
        BTBtargetF_o   = (reset && f_hit) ? target_q[f_idx] : '0;
        PHTindexF_o    = f_pht_idx;
    end

    always_comb begin
        valid_d     = valid_q;
        is_jump_d   = is_jump_q;
        is_branch_d = is_branch_q;
        tag_d       = tag_q;
        target_d    = target_q;
        pht_d       = pht_q;
        ghr_d       = ghr_q;
        e_ctr       = pht_q[PHTindexE_i];
        if (BranchE_i || JumpE_i) begin
            valid_d[e_idx]     = 1'b1;
            tag_d[e_idx]       = e_tag;
            target_d[e_idx]    = TargetE_i;
            is_jump_d[e_idx]   = JumpE_i;
            is_branch_d[e_idx] = BranchE_i;
        end
        if (BranchE_i) begin
            if (BranchTakenE_i) begin
                if (e_ctr != 2'b11)
                    pht_d[PHTindexE_i] = e_ctr + 2'd1;
            end else if (e_ctr != 2'b00) begin
                pht_d[PHTindexE_i] = e_ctr - 2'd1;
            end
            ghr_d = {ghr_q[NUM_GHR_BITS-2:0], BranchTakenE_i};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            is_jump_q   <= '0;
            is_branch_q <= '0;
            ghr_q       <= '0;
            for (int i = 0; i < PHTN; i++)
                pht_q[i] <= 2'b01;
        end else begin
            valid_q     <= valid_d;
            is_jump_q   <= is_jump_d;
            is_branch_q <= is_branch_d;
            ghr_q       <= ghr_d;
            pht_q       <= pht_d;
        end
    end

    // Tag/target need no reset: entries are ignored until valid is set.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Scoreboard bench for the gshare predictor and BTB.
// A reference model supplies expectations alongside hand-derived constants.
module tb_ucsbece154b_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PCF_i;
    logic        BranchTakenF_o;
    logic [31:0] BTBtargetF_o;
    logic [4:0]  PHTindexF_o;
    logic        BranchE_i;
    logic        JumpE_i;
    logic        BranchTakenE_i;
    logic [31:0] PCE_i;
    logic [31:0] TargetE_i;
    logic [4:0]  PHTindexE_i;

    ucsbece154b_branch_predictor #(
        .NUM_BTB_ENTRIES(32),
        .NUM_GHR_BITS(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PCF_i(PCF_i),
        .BranchTakenF_o(BranchTakenF_o),
        .BTBtargetF_o(BTBtargetF_o),
        .PHTindexF_o(PHTindexF_o),
        .BranchE_i(BranchE_i),
        .JumpE_i(JumpE_i),
        .BranchTakenE_i(BranchTakenE_i),
        .PCE_i(PCE_i),
        .TargetE_i(TargetE_i),
        .PHTindexE_i(PHTindexE_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        logic [31:0] tgt;
        logic [4:0]  idx;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    bit          m_valid [32];
    logic [24:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    bit          m_j     [32];
    bit          m_b     [32];
    logic [1:0]  m_pht   [32];
    logic [4:0]  m_ghr;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0;
            m_pht[i]   = 2'b01;
        end
        m_ghr = '0;
    endfunction

    function automatic exp_t model_predict(input logic [31:0] pc,
                                           input string nm);
        exp_t       e;
        logic [4:0] bi;
        bit         hit;
        bi     = pc[6:2];
        hit    = m_valid[bi] && (m_tag[bi] == pc[31:7]);
        e.idx  = pc[6:2] ^ m_ghr;
        e.taken = hit && (m_j[bi] || (m_b[bi] && m_pht[e.idx][1]));
        e.tgt  = hit ? m_tgt[bi] : 32'h0;
        e.name = nm;
        return e;
    endfunction

    function automatic void model_update(input bit br, input bit jp,
                                         input bit tk,
                                         input logic [31:0] pce,
                                         input logic [31:0] tgt,
                                         input logic [4:0] pi);
        logic [4:0] bi;
        bi = pce[6:2];
        if (br || jp) begin
            m_valid[bi] = 1;
            m_tag[bi]   = pce[31:7];
            m_tgt[bi]   = tgt;
            m_j[bi]     = jp;
            m_b[bi]     = br;
        end
        if (br) begin
            if (tk && m_pht[pi] != 2'b11)
                m_pht[pi] = m_pht[pi] + 2'd1;
            else if (!tk && m_pht[pi] != 2'b00)
                m_pht[pi] = m_pht[pi] - 2'd1;
            m_ghr = {m_ghr[3:0], tk};
        end
    endfunction

    task automatic do_update(input bit br, input bit jp, input bit tk,
                             input logic [31:0] pce,
                             input logic [31:0] tgt,
                             input logic [4:0] pi);
        @(negedge clk);
        BranchE_i      = br;
        JumpE_i        = jp;
        BranchTakenE_i = tk;
        PCE_i          = pce;
        TargetE_i      = tgt;
        PHTindexE_i    = pi;
        @(posedge clk);
        #1;
        BranchE_i      = 0;
        JumpE_i        = 0;
        BranchTakenE_i = 0;
        model_update(br, jp, tk, pce, tgt, pi);
    endtask

    task automatic drive_pc(input logic [31:0] pc, input string nm);
        @(negedge clk);
        PCF_i = pc;
        sb.push_back(model_predict(pc, nm));
    endtask

    task automatic drive_pc_exp(input logic [31:0] pc, input string nm,
                                input bit t, input logic [31:0] tg,
                                input logic [4:0] ix);
        exp_t e;
        e.taken = t;
        e.tgt   = tg;
        e.idx   = ix;
        e.name  = nm;
        @(negedge clk);
        PCF_i = pc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                @(negedge clk);
                reset = 1'b1;
            end
            if (k == 2) drive_pc_exp(32'h24, "reset_pc24", 0, 32'h0, 5'd9);
            else        drive_pc_exp(32'h10, "reset_pc10", 0, 32'h0, 5'd4);
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        do_update(0, 1, 0, 32'h24, 32'h80, 5'd0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive_pc_exp(32'h24, "jump_hit", 1, 32'h80, 5'd9);
            else        drive_pc_exp(32'h10, "jump_ghr0", 0, 32'h0, 5'd4);
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
        end
    endtask

    task automatic test_branch_ghr();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin
                    do_update(1, 0, 1, 32'h10, 32'h40, 5'd4);
                    drive_pc_exp(32'h10, "br_idx5", 0, 32'h40, 5'd5);
                end
                1: begin
                    do_update(1, 0, 1, 32'h10, 32'h40, 5'd5);
                    drive_pc_exp(32'h10, "br_idx7", 0, 32'h40, 5'd7);
                end
                2: begin
                    do_update(1, 0, 1, 32'h100, 32'h200, 5'd7);
                    do_update(1, 0, 0, 32'h100, 32'h200, 5'd20);
                    do_update(1, 0, 0, 32'h100, 32'h200, 5'd20);
                    do_update(1, 0, 0, 32'h100, 32'h200, 5'd20);
                    do_update(1, 0, 1, 32'h100, 32'h200, 5'd21);
                    do_update(1, 0, 1, 32'h100, 32'h200, 5'd21);
                    drive_pc_exp(32'h10, "br_trained", 1, 32'h40, 5'd7);
                end
                default: drive_pc_exp(32'h24, "br_jump_kept", 1, 32'h80, 5'd10);
            endcase
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
        end
    endtask

    task automatic test_alias();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) do_update(1, 0, 1, 32'h90, 32'h300, 5'd12);
            case (k)
                0:       drive_pc(32'h90, "alias_miss90");
                1:       drive_pc(32'h10, "alias_miss10");
                default: drive_pc(32'h90, "alias_hit90");
            endcase
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t        e;
        bit          seq [13];
        logic [4:0]  g;
        logic [4:0]  b;
        logic [31:0] pc;
        seq = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int k = 0; k < 13; k++) begin
            g  = {m_ghr[3:0], seq[k]};
            b  = 5'd9 ^ g;
            pc = {25'd0, b, 2'b00};
            do_update(1, 0, seq[k], pc, 32'h1000, 5'd9);
            drive_pc(pc, $sformatf("sat_step%0d", k));
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] pc;
        for (int k = 0; k < 4; k++) begin
            pc = (k == 0) ? 32'h380 : 32'h404;
            if (k < 2) begin
                @(negedge clk);
                BranchE_i      = (k == 0);
                JumpE_i        = (k == 1);
                BranchTakenE_i = 1;
                PCE_i          = pc;
                TargetE_i      = 32'h700 + 32'(k);
                PHTindexE_i    = 5'd2;
                PCF_i          = pc;
                sb.push_back(model_predict(pc, "rdw_old"));
                #1;
            end else begin
                drive_pc(pc - 32'h84 * 32'(k - 2) + 32'h84 * 32'(k - 2),
                         "rdw_new");
                #1;
            end
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s k=%0d: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, k, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
            if (k < 2) begin
                @(posedge clk);
                #1;
                BranchE_i = 0;
                JumpE_i   = 0;
                model_update(k == 0, k == 1, 1, pc, 32'h700 + 32'(k), 5'd2);
            end
        end
        pc = 32'h380;
        drive_pc(pc, "rdw_branch_new");
        #1;
        e = sb.pop_front();
        n_run++;
        if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
            !== {e.taken, e.tgt, e.idx}) begin
            n_fail++;
            $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                     e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                     e.taken, e.tgt, e.idx);
        end
        for (int k = 0; k < 4; k++)
            do_update(k[0], !k[0], 1, 32'h500 + 32'(k) * 4,
                      32'h900 + 32'(k) * 16, 5'(k + 24));
        for (int k = 0; k < 4; k++) begin
            drive_pc(32'h500 + 32'(k) * 4, "b2b_lookup");
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s k=%0d: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, k, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_update(0, 1, 0, 32'h24, 32'h80, 5'd0);
        do_update(1, 0, 1, 32'h10, 32'h40, 5'd4);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive_pc(32'h24, "mid_pre_hit");
                1: begin
                    @(negedge clk);
                    #2;
                    reset = 1'b0;
                    PCF_i = 32'h24;
                    model_reset();
                    sb.push_back(model_predict(32'h24, "mid_async_clear"));
                    e.taken = 0;
                end
                2: drive_pc_exp(32'h24, "mid_after_24", 0, 32'h0, 5'd9);
                default: drive_pc_exp(32'h10, "mid_after_10", 0, 32'h0, 5'd4);
            endcase
            #1;
            e = sb.pop_front();
            n_run++;
            if ({BranchTakenF_o, BTBtargetF_o, PHTindexF_o}
                !== {e.taken, e.tgt, e.idx}) begin
                n_fail++;
                $display("FAIL %s: got t=%0b tgt=%h idx=%0d want t=%0b tgt=%h idx=%0d",
                         e.name, BranchTakenF_o, BTBtargetF_o, PHTindexF_o,
                         e.taken, e.tgt, e.idx);
            end
            if (k == 1) begin
                BranchE_i      = 1;
                BranchTakenE_i = 1;
                PCE_i          = 32'h24;
                TargetE_i      = 32'h55;
                PHTindexE_i    = 5'd9;
                @(posedge clk);
                #1;
                BranchE_i      = 0;
                BranchTakenE_i = 0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        PCF_i          = '0;
        BranchE_i      = 0;
        JumpE_i        = 0;
        BranchTakenE_i = 0;
        PCE_i          = '0;
        TargetE_i      = '0;
        PHTindexE_i    = '0;
        model_reset();
        test_reset();
        test_jump();
        test_branch_ghr();
        test_alias();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
